// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction through a req/ready
// handshake, decodes the RV32I OP-IMM/OP/LUI subset and drives the datapath strobes.
module core_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] imm,
  output logic [3:0]  alu_select,
  output logic        alu_src_imm,
  output logic        reg_write_enable,
  output logic        pc_advance,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  logic [2:0]    r_state;
  logic [31:0]   r_ir;
  logic [31:0]   r_retired;
  logic [1:0]    r_cause;
  logic [TW-1:0] r_tcnt;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_legal;
  logic [3:0]  w_alu;
  logic        w_src_imm;
  logic [31:0] w_imm;

  assign w_opcode = r_ir[6:0];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];

  // alt selects SUB (funct3 000) or SRA (funct3 101); callers decide when it applies.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_funct3 = alt ? 4'd1 : 4'd0;
      3'b001:  alu_from_funct3 = 4'd2;
      3'b010:  alu_from_funct3 = 4'd3;
      3'b011:  alu_from_funct3 = 4'd4;
      3'b100:  alu_from_funct3 = 4'd5;
      3'b101:  alu_from_funct3 = alt ? 4'd7 : 4'd6;
      3'b110:  alu_from_funct3 = 4'd8;
      default: alu_from_funct3 = 4'd9;
    endcase
  endfunction

  always_comb begin
    w_legal   = 1'b0;
    w_alu     = 4'd0;
    w_src_imm = 1'b0;
    w_imm     = {{20{r_ir[31]}}, r_ir[31:20]};
    case (w_opcode)
      OPC_OPIMM: begin
        w_src_imm = 1'b1;
        w_alu     = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && r_ir[30]);
        case (w_funct3)
          3'b001:  w_legal = (w_funct7 == 7'b0000000);
          3'b101:  w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
          default: w_legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_alu   = alu_from_funct3(w_funct3, r_ir[30]);
        w_legal = (w_funct7 == 7'b0000000) ||
                  ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      OPC_LUI: begin
        w_legal   = 1'b1;
        w_alu     = 4'd10;
        w_src_imm = 1'b1;
        w_imm     = {r_ir[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ir      <= NOP;
      r_retired <= '0;
      r_cause   <= '0;
      r_tcnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tcnt <= '0;
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          // A ready on the final allowed cycle still completes the fetch.
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_tcnt  <= '0;
            r_state <= S_DECODE;
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_cause <= CAUSE_TIMEOUT;
            r_state <= S_TRAP;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_cause <= CAUSE_ILLEGAL;
            r_state <= S_TRAP;
          end
        end
        S_EXEC: r_state <= S_WB;
        S_WB: begin
          r_retired <= r_retired + 32'd1;
          r_tcnt    <= '0;
          r_state   <= run ? S_FETCH : S_IDLE;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req         = (r_state == S_FETCH);
  assign reg_write_enable = (r_state == S_WB);
  assign pc_advance       = (r_state == S_WB);
  assign busy             = (r_state != S_IDLE) && (r_state != S_TRAP);
  assign trap             = (r_state == S_TRAP);
  assign trap_cause       = r_cause;
  assign retired          = r_retired;
  assign instruction      = r_ir;
  assign imm              = w_imm;
  assign alu_select       = w_alu;
  assign alu_src_imm      = w_src_imm;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a phase-level reference model checked every
// cycle, plus literal expectations for the listed instruction scenarios.
module tb_core_sequencer;

  localparam int TIMEOUT = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] SUB   = 32'h4020_8133;
  localparam logic [31:0] XORI  = 32'hFFF0_C093;
  localparam logic [31:0] LUI   = 32'h1234_5037;
  localparam logic [31:0] SRAI  = 32'h4020_D093;
  localparam logic [31:0] BADOP = 32'h4020_90B3;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] instruction, imm, retired;
  logic [3:0]  alu_select;
  logic        alu_src_imm, reg_write_enable, pc_advance, busy, trap;
  logic [1:0]  trap_cause;

  int n_checks = 0;
  int n_errs   = 0;
  bit started  = 1'b0;

  core_sequencer #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .imm(imm), .alu_select(alu_select),
    .alu_src_imm(alu_src_imm), .reg_write_enable(reg_write_enable),
    .pc_advance(pc_advance), .busy(busy), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase of the current instruction and architectural counters.
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_WB = 4, P_TRAP = 5;
  int          m_phase = P_IDLE;
  int          m_fetch_cycles = 0;
  logic [31:0] m_ir = NOP;
  logic [31:0] m_ret = '0;
  logic [1:0]  m_cause = '0;

  function automatic bit ref_legal(input logic [31:0] w);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    if (op == 7'h37) return 1'b1;
    if (op == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (op == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] w);
    int tbl [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int r;
    if (w[6:0] == 7'h37) return 4'd10;
    r = tbl[w[14:12]];
    if (w[14:12] == 3'd5 && w[30]) r = 7;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[30]) r = 1;
    return 4'(r);
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic signed [31:0] s;
    if (w[6:0] == 7'h37) return w & 32'hFFFF_F000;
    s = w;
    return s >>> 20;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_ir = NOP; m_ret = '0; m_cause = '0; m_fetch_cycles = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (run) begin m_phase = P_FETCH; m_fetch_cycles = 0; end
        P_FETCH: begin
          m_fetch_cycles++;
          if (imem_ready) begin m_ir = imem_rdata; m_phase = P_DECODE; end
          else if (m_fetch_cycles == TIMEOUT) begin m_cause = 2'd2; m_phase = P_TRAP; end
        end
        P_DECODE: if (ref_legal(m_ir)) m_phase = P_EXEC;
                  else begin m_cause = 2'd1; m_phase = P_TRAP; end
        P_EXEC: m_phase = P_WB;
        P_WB: begin
          m_ret = m_ret + 32'd1;
          m_fetch_cycles = 0;
          m_phase = run ? P_FETCH : P_IDLE;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", 32'(busy), 32'(m_phase >= P_FETCH && m_phase <= P_WB));
      chk("imem_req", 32'(imem_req), 32'(m_phase == P_FETCH));
      chk("trap", 32'(trap), 32'(m_phase == P_TRAP));
      chk("reg_write_enable", 32'(reg_write_enable), 32'(m_phase == P_WB));
      chk("pc_advance", 32'(pc_advance), 32'(m_phase == P_WB));
      chk("trap_cause", 32'(trap_cause), 32'(m_cause));
      chk("retired", retired, m_ret);
      chk("instruction", instruction, m_ir);
      if (m_phase == P_EXEC || m_phase == P_WB || (m_phase == P_DECODE && ref_legal(m_ir))) begin
        chk("alu_select", 32'(alu_select), 32'(ref_alu(m_ir)));
        chk("alu_src_imm", 32'(alu_src_imm), 32'(m_ir[6:0] != 7'h33));
        chk("imm", imm, ref_imm(m_ir));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts with the DUT in FETCH; returns with it in DECODE.
  task automatic fetch(input logic [31:0] ins, input int waits, output int reqc);
    reqc = 0;
    for (int i = 0; i < waits; i++) begin
      if (imem_req) reqc++;
      imem_ready = 1'b0;
      tick();
    end
    if (imem_req) reqc++;
    imem_ready = 1'b1;
    imem_rdata = ins;
    tick();
    imem_ready = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  int reqc;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    chk("rst_instruction", instruction, 32'h0000_0013);
    chk("rst_retired", retired, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    tick();

    run = 1'b1;
    tick();
    fetch(ADDI, 0, reqc);
    chk("addi_req_cycles", 32'(reqc), 32'd1);
    tick(); tick();
    chk("addi_wb_we", 32'(reg_write_enable), 32'd1);
    chk("addi_wb_pc", 32'(pc_advance), 32'd1);
    chk("addi_alu", 32'(alu_select), 32'd0);
    chk("addi_src_imm", 32'(alu_src_imm), 32'd1);
    chk("addi_imm", imm, 32'd5);
    tick();
    chk("addi_retired", retired, 32'd1);

    fetch(SUB, 3, reqc);
    chk("sub_req_cycles", 32'(reqc), 32'd4);
    tick(); tick();
    chk("sub_alu", 32'(alu_select), 32'd1);
    chk("sub_src_imm", 32'(alu_src_imm), 32'd0);
    tick();

    fetch(XORI, 0, reqc);
    tick(); tick();
    chk("xori_imm", imm, 32'hFFFF_FFFF);
    chk("xori_alu", 32'(alu_select), 32'd5);
    tick();

    fetch(LUI, 0, reqc);
    tick();
    chk("lui_exec_we", 32'(reg_write_enable), 32'd0);
    tick();
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_alu", 32'(alu_select), 32'd10);
    chk("lui_wb_we", 32'(reg_write_enable), 32'd1);
    tick();
    chk("lui_after_we", 32'(reg_write_enable), 32'd0);
    chk("lui_retired", retired, 32'd4);

    fetch(SRAI, 0, reqc);
    tick(); tick();
    chk("srai_alu", 32'(alu_select), 32'd7);
    chk("srai_imm", imm, 32'h0000_0402);
    tick();
    chk("srai_retired", retired, 32'd5);

    // Asynchronous reset in the middle of a FETCH cycle.
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_imem_req", 32'(imem_req), 32'd0);
    chk("arst_instruction", instruction, 32'h0000_0013);
    chk("arst_retired", retired, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Ready arrives on the last allowed FETCH cycle; run drops mid-instruction.
    fetch(ADDI, TIMEOUT - 1, reqc);
    chk("late_ready_no_trap", 32'(trap), 32'd0);
    chk("late_ready_req_cycles", 32'(reqc), 32'(TIMEOUT));
    run = 1'b0;
    tick(); tick();
    chk("late_ready_wb_pc", 32'(pc_advance), 32'd1);
    tick();
    chk("run_low_idle_busy", 32'(busy), 32'd0);
    chk("run_low_retired", retired, 32'd1);
    tick();
    chk("idle_stays", 32'(imem_req), 32'd0);

    run = 1'b1;
    tick();
    fetch(BADOP, 0, reqc);
    tick();
    chk("badop_trap", 32'(trap), 32'd1);
    chk("badop_cause", 32'(trap_cause), 32'd1);
    chk("badop_pc", 32'(pc_advance), 32'd0);
    repeat (3) tick();
    chk("trap_sticky", 32'(trap), 32'd1);
    chk("trap_retired", retired, 32'd1);

    do_reset();
    fetch(ECALL, 0, reqc);
    tick();
    chk("ecall_trap", 32'(trap), 32'd1);
    chk("ecall_cause", 32'(trap_cause), 32'd1);
    chk("ecall_pc", 32'(pc_advance), 32'd0);

    do_reset();
    imem_ready = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("timeout_pre_trap", 32'(trap), 32'd0);
    tick();
    chk("timeout_trap", 32'(trap), 32'd1);
    chk("timeout_cause", 32'(trap_cause), 32'd2);
    chk("timeout_busy", 32'(busy), 32'd0);

    run = 1'b0;
    do_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the processor core: program counter, 2R/1W register file and 4-bit-select ALU.
- Fetches each instruction from instruction memory through a req/ready handshake and latches it in an instruction register (IR).
- Decodes the RV32I integer subset OP-IMM, OP and LUI into register-file write-enable, ALU select, operand-B select and immediate.
- Advances the PC once per retired instruction; traps on illegal opcodes or fetch timeout.

Parameters:
TIMEOUT, 16, max cycles in FETCH waiting for imem_ready before trapping (>=1).
TW, 5, width of timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous active-high reset.
run  in  1  level; start/continue sequencing from IDLE.
imem_req  out  1  fetch request, held high while in FETCH.
imem_ready  in  1  memory has valid imem_rdata this cycle.
imem_rdata  in  32  fetched instruction word.
instruction  out  32  IR contents (drives rs1/rs2/rd fields).
imm  out  32  decoded immediate: I-type sign-extended, or U-type {IR[31:12],12'b0}.
alu_select  out  4  ALU op code (see Behaviour).
alu_src_imm  out  1  1 = ALU B is imm, 0 = rs2 data.
reg_write_enable  out  1  register-file write strobe.
pc_advance  out  1  one-cycle PC increment strobe.
busy  out  1  high in any state except IDLE and TRAP.
trap  out  1  high in TRAP.
trap_cause  out  2  0 none, 1 illegal instruction, 2 fetch timeout.
retired  out  32  count of retired instructions, wraps at 2^32.

Behaviour:
Reset (async, immediate):
- State goes to IDLE.
- IR = 32'h00000013 (NOP), retired = 0, trap_cause = 0.
- All strobes (imem_req, reg_write_enable, pc_advance) = 0; busy = 0; trap = 0.

ALU codes:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- Decode is from funct3, plus IR[30] for SUB/SRA.
- OP-IMM never produces SUB. SRAI uses IR[30].
- LUI uses PASSB with alu_src_imm = 1.

States:
- IDLE: if run, go to FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req = 1; timeout counter increments each cycle.
  - If imem_ready: load IR from imem_rdata, clear counter, go to DECODE.
  - Else if counter reaches TIMEOUT-1: go to TRAP with cause 2.
  - If imem_ready coincides with the timeout cycle, imem_ready wins.
- DECODE:
  - Decode opcode = IR[6:0]. Legal values: 0010011 (OP-IMM), 0110011 (OP), 0110111 (LUI).
  - OP requires funct7 = 0000000, or 0100000 only with funct3 000/101.
  - OP-IMM shifts require IR[31:25] = 0000000, or 0100000 for SRAI.
  - Legal: go to EXEC. Illegal: go to TRAP with cause 1; no write, no PC advance.
- EXEC:
  - alu_select, alu_src_imm and imm are valid; ALU result settles.
  - Go to WB.
- WB:
  - Assert reg_write_enable = 1 and pc_advance = 1 for exactly one cycle; retired increments.
  - Then: FETCH if run is still high, else IDLE.
  - rd = x0 still asserts write; the register file ignores x0.
- TRAP:
  - Sticky; trap = 1, trap_cause held.
  - Left only by rst; run is ignored.

Output timing:
- alu_select, alu_src_imm and imm are combinational from IR and are stable from DECODE through WB.
- In IDLE, FETCH and TRAP: reg_write_enable = 0 and pc_advance = 0.
- Latency: 4 cycles per instruction with a zero-wait fetch (FETCH, DECODE, EXEC, WB).
- Deasserting run mid-instruction completes the current instruction, then returns to IDLE.

Test Plan:
- Reset mid-FETCH (rst pulsed asynchronously) -> state IDLE immediately; busy = 0, imem_req = 0, instruction = 32'h00000013, retired = 0.
- run = 1; fetch 32'h00500093 (addi x1,x0,5) with zero wait -> DECODE/EXEC/WB follow; in WB reg_write_enable = 1, pc_advance = 1, alu_select = 0, alu_src_imm = 1, imm = 5; retired = 1.
- Fetch 32'h40208133 (sub x2,x1,x2) after 3 wait cycles -> imem_req high for 4 cycles; then alu_select = 1, alu_src_imm = 0.
- Fetch 32'hFFF0C093 (xori x1,x1,-1) -> imm = 32'hFFFFFFFF, alu_select = 5.
- Fetch 32'h12345037 (lui x0,0x12345) -> imm = 32'h12345000, alu_select = 10, reg_write_enable pulses once.
- Fetch 32'h00000073 (ecall) -> TRAP, trap_cause = 1, no pc_advance. Separately, hold imem_ready = 0 for 16 cycles -> TRAP, trap_cause = 2. Ready on cycle 16 -> DECODE, no trap.
